// File: rtl/uart_prog_loader.sv
// ============================================================================
// uart_prog_loader: framed UART image (A5, len, LE words, sum) -> imem writes.
// Optional ack byte on TX when LOADER_ACK_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_prog_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 4096,
  parameter int          TIMEOUT_CYC = 5000000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog,
  input  logic        rx_data_present,
  input  logic [7:0]  uart_dout,
  output logic        rx_ren,
`ifdef LOADER_ACK_EN
  input  logic        tx_full,
  output logic        tx_wen,
  output logic [7:0]  uart_din,
`endif
  output logic        imem_prog_ena,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [16:0] MAX_W   = 17'(MAX_WORDS);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYC);
  localparam logic [7:0]  SYNC_B  = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        ren_last_q;
  logic [15:0] len_q, len_d;
  logic [15:0] wc_q, wc_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        consuming;
  logic        timed;
  logic        pop;
  logic        tmo_hit;
  logic        wr;
  logic [15:0] n_len;

`ifdef LOADER_ACK_EN
  logic        ack_pend_q, ack_pend_d;
  logic [7:0]  ack_byte_q, ack_byte_d;
`endif

  always_comb begin
    consuming = (state_q == S_SYNC) || (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    timed     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                (state_q == S_WRITE) || (state_q == S_CSUM);
    // pop only with ren low last cycle, so the FIFO head has time to advance
    pop       = prog && consuming && rx_data_present && !ren_last_q;
    tmo_hit   = timed && !pop && ((tmo_q + 32'd1) >= TMO_LIM);
    n_len     = {uart_dout, len_q[7:0]};
    wr        = prog && (state_q == S_WRITE);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    done_d  = done_q;
    error_d = error_q;

    if (!prog) begin
      state_d = S_IDLE;
    end else begin
      if (timed && !pop) tmo_d = tmo_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          state_d = S_SYNC;
          done_d  = 1'b0;
          error_d = 1'b0;
          wc_d    = '0;
          len_d   = '0;
          bidx_d  = '0;
          word_d  = '0;
          sum_d   = '0;
        end
        S_SYNC: begin
          if (pop && uart_dout == SYNC_B) state_d = S_LEN0;
        end
        S_LEN0: begin
          if (pop) begin
            len_d[7:0] = uart_dout;
            state_d    = S_LEN1;
          end
        end
        S_LEN1: begin
          if (pop) begin
            len_d = n_len;
            if ({1'b0, n_len} > MAX_W) state_d = S_ERR;
            else if (n_len == 16'd0)   state_d = S_CSUM;
            else                       state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (pop) begin
            word_d[{bidx_q, 3'b000} +: 8] = uart_dout;
            sum_d  = sum_q + uart_dout;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          wc_d    = wc_q + 16'd1;
          state_d = ((wc_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (pop) state_d = (uart_dout == sum_q) ? S_DONE : S_ERR;
        end
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
      if (tmo_hit) state_d = S_ERR;
      if (state_d == S_DONE && state_q != S_DONE) done_d  = 1'b1;
      if (state_d == S_ERR  && state_q != S_ERR)  error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      ren_last_q <= 1'b0;
      len_q      <= '0;
      wc_q       <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ren_last_q <= pop;
      len_q      <= len_d;
      wc_q       <= wc_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

`ifdef LOADER_ACK_EN
  always_comb begin
    ack_pend_d = ack_pend_q;
    ack_byte_d = ack_byte_q;
    if (!prog) begin
      ack_pend_d = 1'b0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      ack_pend_d = 1'b1;
      ack_byte_d = 8'h06;
    end else if (state_d == S_ERR && state_q != S_ERR) begin
      ack_pend_d = 1'b1;
      ack_byte_d = 8'h15;
    end else if (ack_pend_q && !tx_full) begin
      ack_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ack_pend_q <= 1'b0;
      ack_byte_q <= 8'h00;
    end else begin
      ack_pend_q <= ack_pend_d;
      ack_byte_q <= ack_byte_d;
    end
  end

  assign tx_wen   = ack_pend_q && !tx_full && prog;
  assign uart_din = ack_byte_q;
`endif

  assign rx_ren        = pop;
  assign imem_prog_ena = wr;
  assign imem_en       = wr;
  assign imem_addr     = wr ? (BASE_ADDR + {14'd0, wc_q, 2'b00}) : 32'd0;
  assign imem_din      = wr ? word_q : 32'd0;
  assign busy          = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_CSUM);
  assign done          = done_q;
  assign error         = error_q;
  assign word_count    = wc_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ============================================================================
// tb_uart_prog_loader: directed bench for the UART program loader.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_prog_loader;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        prog = 1'b0;
  logic        rx_data_present = 1'b0;
  logic [7:0]  uart_dout = 8'h00;
  logic        rx_ren;
  logic        imem_prog_ena;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;
`ifdef LOADER_ACK_EN
  logic        tx_full = 1'b0;
  logic        tx_wen;
  logic [7:0]  uart_din;
`endif

  uart_prog_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .MAX_WORDS   (4096),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk             (clk),
    .Rst             (Rst),
    .prog            (prog),
    .rx_data_present (rx_data_present),
    .uart_dout       (uart_dout),
    .rx_ren          (rx_ren),
`ifdef LOADER_ACK_EN
    .tx_full         (tx_full),
    .tx_wen          (tx_wen),
    .uart_din        (uart_din),
`endif
    .imem_prog_ena   (imem_prog_ena),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_din        (imem_din),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .word_count      (word_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_din[$];
  logic [7:0]  seq[$];
  int          ren_double = 0;
  int          en_mismatch = 0;
  logic        ren_prev = 1'b0;
  int          ack_cnt = 0;
  logic [7:0]  ack_last = 8'h00;

  always @(negedge clk) begin
    if (imem_prog_ena) begin
      wr_addr.push_back(imem_addr);
      wr_din.push_back(imem_din);
    end
    if (imem_en !== imem_prog_ena) en_mismatch++;
    if (rx_ren && ren_prev) ren_double++;
    ren_prev = rx_ren;
`ifdef LOADER_ACK_EN
    if (tx_wen) begin
      ack_cnt++;
      ack_last = uart_din;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(negedge clk);
    uart_dout = b;
    rx_data_present = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (rx_ren) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1 rx_data_present = 1'b0;
    end else begin
      rx_data_present = 1'b0;
      checks++;
      fails++;
      $error("FAIL pop_timeout: byte %0h observed no rx_ren expected rx_ren=1", b);
    end
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic load_image(input logic [7:0] csum);
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, csum};
    send_seq();
  endtask

  task automatic restart();
    @(negedge clk);
    prog = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_din.delete();
    prog = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset values
    rx_data_present = 1'b1;
    #12;
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_wc",    {16'd0, word_count}, 32'd0);
    check("rst_ren",   {31'd0, rx_ren}, 32'd0);
    check("rst_wr",    {31'd0, imem_prog_ena}, 32'd0);
    @(negedge clk);
    Rst = 1'b1;
    wait_cyc(2);
    check("idle_noprog_ren", {31'd0, rx_ren}, 32'd0);
    @(negedge clk);
    prog = 1'b1;
    #1 check("idle_prog_ren", {31'd0, rx_ren}, 32'd0);
    rx_data_present = 1'b0;

    // T1: good image with a leading junk byte
`ifdef LOADER_ACK_EN
    tx_full = 1'b1;
`endif
    send_byte(8'h5A);
    check("t1_junk_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    check("t1_sync_busy", {31'd0, busy}, 32'd1);
    seq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_seq();
    wait_cyc(2);
    check("t1_nwr",   wr_addr.size(), 32'd2);
    check("t1_addr0", wr_addr.size() > 0 ? wr_addr[0] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("t1_din0",  wr_din.size()  > 0 ? wr_din[0]  : 32'hDEAD_BEEF, 32'h0000_0013);
    check("t1_addr1", wr_addr.size() > 1 ? wr_addr[1] : 32'hDEAD_BEEF, 32'h0000_0004);
    check("t1_din1",  wr_din.size()  > 1 ? wr_din[1]  : 32'hDEAD_BEEF, 32'h0010_0093);
    check("t1_done",  {31'd0, done}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_wc",    {16'd0, word_count}, 32'd2);
    check("t1_busy",  {31'd0, busy}, 32'd0);
`ifdef LOADER_ACK_EN
    wait_cyc(8);
    check("t1_ack_held", ack_cnt, 32'd0);
    tx_full = 1'b0;
    wait_cyc(4);
    check("t1_ack_cnt",  ack_cnt, 32'd1);
    check("t1_ack_byte", {24'd0, ack_last}, 32'h06);
`endif

    // T2: bad checksum; done sticky across prog fall
    @(negedge clk);
    prog = 1'b0;
    wait_cyc(2);
    check("t2_done_after_fall", {31'd0, done}, 32'd1);
    wr_addr.delete();
    wr_din.delete();
    ack_cnt = 0;
    prog = 1'b1;
    wait_cyc(2);
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    check("t2_wc_cleared",   {16'd0, word_count}, 32'd0);
    load_image(8'hB7);
    wait_cyc(2);
    check("t2_nwr",  wr_addr.size(), 32'd2);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_done",  {31'd0, done}, 32'd0);
    check("t2_wc",    {16'd0, word_count}, 32'd2);
`ifdef LOADER_ACK_EN
    wait_cyc(2);
    check("t2_ack_cnt",  ack_cnt, 32'd1);
    check("t2_ack_byte", {24'd0, ack_last}, 32'h15);
`endif

    // T3: oversize length
    restart();
    seq = '{8'hA5, 8'h00, 8'h20};
    send_seq();
    wait_cyc(2);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_nwr",   wr_addr.size(), 32'd0);
    check("t3_wc",    {16'd0, word_count}, 32'd0);

    // T4: inter-byte timeout
    restart();
    seq = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_seq();
    wait_cyc(TMO / 2);
    check("t4_early_error", {31'd0, error}, 32'd0);
    check("t4_early_busy",  {31'd0, busy}, 32'd1);
    wait_cyc(TMO);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_busy",  {31'd0, busy}, 32'd0);
    check("t4_nwr",   wr_addr.size(), 32'd0);

    // T5: prog falls mid-word, then a clean reload
    restart();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_seq();
    wait_cyc(2);
    uart_dout = 8'h00;
    rx_data_present = 1'b1;
    prog = 1'b0;
    #1 check("t5_no_pop_on_fall", {31'd0, rx_ren}, 32'd0);
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    rx_data_present = 1'b0;
    wait_cyc(2);
    check("t5_nwr", wr_addr.size(), 32'd0);
    prog = 1'b1;
    wait_cyc(2);
    load_image(8'hB6);
    wait_cyc(2);
    check("t5_nwr2",  wr_addr.size(), 32'd2);
    check("t5_addr0", wr_addr.size() > 0 ? wr_addr[0] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("t5_din1",  wr_din.size()  > 1 ? wr_din[1]  : 32'hDEAD_BEEF, 32'h0010_0093);
    check("t5_done",  {31'd0, done}, 32'd1);

    // T6: async reset mid-DATA
    restart();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_seq();
    wait_cyc(2);
    check("t6_pre_wc",   {16'd0, word_count}, 32'd1);
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    uart_dout = 8'h10;
    rx_data_present = 1'b1;
    #1 check("t6_pre_ren", {31'd0, rx_ren}, 32'd1);
    Rst = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_wc",   {16'd0, word_count}, 32'd0);
    check("t6_ren",  {31'd0, rx_ren}, 32'd0);
    check("t6_err",  {31'd0, error}, 32'd0);
    check("t6_addr", imem_addr, 32'd0);
    check("t6_wr",   {31'd0, imem_prog_ena}, 32'd0);
    rx_data_present = 1'b0;
    @(negedge clk);
    Rst = 1'b1;
    wait_cyc(2);

    check("ren_one_cycle", ren_double, 32'd0);
    check("en_eq_prog",    en_mismatch, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader between uart_controller and the Memory_Controller instruction-memory program port.
- While prog is high, pops bytes from the UART RX FIFO, parses a framed image (sync, length, little-endian words, checksum) and writes each word into imem.
- Reports busy/done/error for the debug LEDs and display.

Parameters:
BASE_ADDR, 32'h0000_0000, imem byte address of the first word
MAX_WORDS, 4096, largest accepted word count; larger lengths abort
TIMEOUT_CYC, 5000000, max clk cycles between bytes after sync (100 ms at 50 MHz)

Ports:
clk  in  1  system clock (clk_50M domain)
Rst  in  1  asynchronous, active-low reset
prog  in  1  loader enable; level
rx_data_present  in  1  UART RX FIFO non-empty
uart_dout  in  8  RX FIFO head byte, valid while rx_data_present=1
rx_ren  out  1  pop RX FIFO head; one-cycle pulse
imem_prog_ena  out  1  imem program write strobe
imem_en  out  1  imem enable, asserted with imem_prog_ena
imem_addr  out  32  imem byte address
imem_din  out  32  instruction word
busy  out  1  high from sync byte accepted until DONE/ERR/IDLE
done  out  1  image loaded and checksum matched; sticky
error  out  1  aborted load; sticky
word_count  out  16  words written in the current load

Behaviour:
- Reset (Rst=0, async): state IDLE; all outputs 0; internal length, index, checksum and timeout counter cleared.
- Byte read rule: in a byte-consuming state with rx_data_present=1 and rx_ren low last cycle, assert rx_ren for one cycle and sample uart_dout in that same cycle. Consecutive pops are at least 2 cycles apart.
- States:
  - IDLE: prog=1 goes to SYNC next cycle, clears done/error/word_count. No pops in IDLE.
  - SYNC: pop bytes; 8'hA5 goes to LEN0 and sets busy; any other byte is discarded. No timeout in SYNC.
  - LEN0/LEN1: pop the length low byte, then the high byte (16-bit word count N).
    - N > MAX_WORDS goes to ERR.
    - N = 0 goes to CSUM.
    - Otherwise goes to DATA.
  - DATA: pop 4 bytes and assemble little-endian (first byte = [7:0]). After the 4th byte go to WRITE. Checksum accumulates every data byte, sum mod 256.
  - WRITE: exactly one cycle with imem_prog_ena=imem_en=1, imem_addr=BASE_ADDR+4*idx, imem_din=word. Next cycle idx and word_count increment; go to CSUM if idx+1==N, else DATA. Outputs are 0 in every other state.
  - CSUM: pop one byte; it must equal the 8-bit sum of data bytes. Match goes to DONE, mismatch goes to ERR. Words already written stay written.
  - DONE: busy=0, done=1. ERR: busy=0, error=1. Both hold until prog=0.
- Timeout: in LEN0..CSUM, the counter resets on each pop and increments otherwise. Reaching TIMEOUT_CYC goes to ERR.
- prog=0 in any state: go to IDLE next cycle. Clear busy, no further pops or writes. done/error are cleared on the next prog rise, not on the fall.
- Address arithmetic wraps mod 2^32; width is 32 bits.
- A byte arriving in the same cycle prog falls is not popped.

Optional Feature:
- Macro LOADER_ACK_EN.
- When defined, adds ports: tx_full in 1, tx_wen out 1, uart_din out 8.
  - On entry to DONE the loader sends one ack byte 8'h06; on entry to ERR it sends 8'h15.
  - tx_wen is a one-cycle pulse, issued once tx_full=0. It is held pending while tx_full=1.
  - A pending ack is dropped if prog falls.
  - Reset values: tx_wen=0, uart_din=0.
- Undefined: no TX ports and no ack traffic.

Test Plan:
- Feed bytes 5A A5 02 00 13 00 00 00 93 00 10 00 B6 with prog=1.
  - Required: 5A is discarded.
  - Two imem writes: addr 0x0 din 0x00000013, then addr 0x4 din 0x00100093.
  - Final state: done=1, word_count=2, error=0.
- Same image with checksum byte B7 -> both words written, then error=1, done=0.
- Feed A5 00 20 (N=8192 > 4096) -> error=1, zero imem writes.
- Feed A5 01 00 13, then nothing for TIMEOUT_CYC cycles -> error=1, no write.
- Deassert prog after 2 of 4 data bytes -> busy=0 next cycle, no write. Re-asserting prog and sending a full image loads correctly from BASE_ADDR.
- Assert Rst=0 mid-DATA -> all outputs 0 immediately, no clk edge required. With LOADER_ACK_EN, a successful load produces a single tx_wen pulse with uart_din=06, delayed until tx_full=0.
